ahb_multiport_mem: RTL and testbench
====================================

// Module: ahb_multiport_mem
// PURPOSE
//  Parametrised AHB-Lite slave memory for the zscale simulation harness and FPGA smoke builds.
//  Serves NPORTS independent AHB-Lite master ports (imem, dmem, ...) against one shared byte array.
//  Adds protocol features the two-port harness memory lacks:
//  - SEQ/BUSY bursts, fixed or pseudo-random wait states;
//  - two-cycle ERROR response for bad accesses;
//  - data-phase HWDATA capture;
//  - console / pass MMIO reported on ports instead of $finish.
// PARAMETERS
//  NPORTS       2             number of AHB-Lite slave ports
//  XLEN         32            data/address width, 32 or 64
//  MEM_BYTES    65536         memory size in bytes, power of 2, multiple of XLEN/8
//  WAIT_MODE    0             0: fixed WAIT_CYCLES per beat; 1: LFSR-random 0..WAIT_CYCLES per beat
//  WAIT_CYCLES  0             wait states per beat, 0..15
//  LFSR_SEED    32'hACE1_2468 per-port seed = LFSR_SEED ^ port index, must be nonzero
//  CONSOLE_ADDR 32'h1000_0000 write-only byte sink
//  PASS_ADDR    32'h2000_0000 write-only test-pass register
//  PASS_VALUE   123456789     value that sets tests_passed
// PORTS
//  clk           in   1           clock, rising edge
//  reset         in   1           synchronous, active-high
//  htrans        in   2*NPORTS    per-port HTRANS, port p at [2p+1:2p]
//  haddr         in   XLEN*NPORTS per-port HADDR
//  hwrite        in   NPORTS      per-port HWRITE
//  hsize         in   3*NPORTS    per-port HSIZE
//  hburst        in   3*NPORTS    per-port HBURST, informational only
//  hwdata        in   XLEN*NPORTS per-port HWDATA, sampled in the data phase
//  hrdata        out  XLEN*NPORTS per-port HRDATA
//  hready        out  NPORTS      per-port HREADYOUT, also used as that port's HREADY
//  hresp         out  NPORTS      per-port HRESP, 0=OKAY 1=ERROR
//  console_valid out  1           1-cycle strobe on an accepted console write
//  console_data  out  8           HWDATA[7:0] of that write
//  tests_passed  out  1           sticky; set by a PASS_ADDR write of PASS_VALUE
// BEHAVIOUR
//  Reset: hready=all 1, hresp=0, hrdata=0, console_valid=0, tests_passed=0; ports go to IDLE.
//   LFSRs reload their seeds. Memory contents are NOT cleared.
//   Reset mid-burst abandons the beat; a pending write is dropped.
//  Address phase accepted when hready[p]=1 and htrans[p] is NONSEQ(2'b10) or SEQ(2'b11).
//   Latch addr, size, write; the port enters the data phase next cycle.
//   IDLE(00) and BUSY(01) give a zero-wait OKAY data phase with no memory effect.
//  Per-port FSM: IDLE -> WAIT (counter>0) or DATA (counter=0); WAIT -> DATA when counter hits 0.
//   ERR1 -> ERR2 -> IDLE, or accept a new address phase in ERR2.
//   Counter loads WAIT_CYCLES, or LFSR[3:0] mod (WAIT_CYCLES+1) when WAIT_MODE=1.
//   LFSR is a 16-bit Galois, taps 0xB400, stepped once per accepted beat.
//  WAIT: hready=0, hresp=0.
//  DATA: hready=1, hresp=0.
//   Read: hrdata = memory word at addr with low log2(XLEN/8) bits cleared, full word, no lane shifting.
//   Write: commit hwdata byte lanes selected by the size/addr strobe at the clock edge ending DATA.
//   Zero-wait latency: read data is valid in the cycle after the address phase; back-to-back beats pipeline.
//  ERROR when any holds:
//   - addr >= MEM_BYTES and addr is not a MMIO address;
//   - hsize > log2(XLEN/8);
//   - addr misaligned to its hsize;
//   - read from a MMIO address.
//   ERR1 drives hready=0 hresp=1; ERR2 drives hready=1 hresp=1. Memory is never modified.
//  MMIO writes: console_valid pulses in the DATA cycle. tests_passed sets and stays set until reset.
//  Same-cycle collisions: writes from several ports to one byte resolve to the highest port index.
//   A read in the same cycle as a write to the same word returns pre-write data.
//  Address wrap: none. haddr >= MEM_BYTES is an error, not aliased.
//  64-bit mode: word index = addr>>3; strobes cover 8 lanes. hsize=3 is legal only when XLEN=64.
// STRUCTURE
//  ahb_mem_defs.vh: HTRANS_*, HRESP_*, FSM state localparams, strobe function strb(size, addr_lo).
//  Sub-module ahb_mem_port: per-port FSM, wait counter, LFSR, error decode.
//   Instantiated NPORTS times via generate.
//   Outputs a write request (wen, widx, wstrb, wdata) and a read index to the top.
//  Top owns the memory array, the write-priority loop, MMIO decode, console and pass logic.
// TESTING
//  1. WAIT_CYCLES=0, port0 NONSEQ read 0x100, mem[0x40]=0xDEADBEEF
//     -> hrdata=0xDEADBEEF with hready=1 one cycle after the address phase.
//  2. WAIT_CYCLES=3, port1 word write 0x11223344 @0x200, then read back
//     -> hready low for exactly 3 cycles on each beat; readback 0x11223344.
//  3. Byte write 0xAA @0x203 over 0x11223344 -> word reads 0xAA223344; hsize=1 @0x201 -> ERR1/ERR2, memory unchanged.
//  4. Read @0x0001_0000 -> hready=0/hresp=1, then hready=1/hresp=1, then IDLE with hresp=0.
//  5. Ports 0 and 1 write 0x1 and 0x2 to 0x300 in the same cycle -> mem word 0x2.
//     A simultaneous read of 0x300 returns the old value.
//  6. Write 'A' to CONSOLE_ADDR -> console_valid pulses one cycle with console_data=0x41.
//     Write 123456789 to PASS_ADDR -> tests_passed=1 until reset; reset mid WAIT -> hready=1 next cycle.

Source files
------------

// File: rtl/ahb_multiport_mem_pkg.sv
// rtl/ahb_multiport_mem_pkg.sv - shared encodings and byte-strobe helper for the AHB-Lite multiport memory
package ahb_multiport_mem_pkg;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } port_state_e;

    // Eight-lane strobe; 32-bit instances use only the low four lanes.
    function automatic logic [7:0] strb(input logic [2:0] size, input logic [2:0] addr_lo);
        logic [7:0] m;
        case (size)
            3'd0:    m = 8'h01;
            3'd1:    m = 8'h03;
            3'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << addr_lo;
    endfunction

endpackage

// File: rtl/ahb_multiport_mem_port.sv
// rtl/ahb_multiport_mem_port.sv - one AHB-Lite slave port: transfer FSM, wait counter, LFSR, error decode
module ahb_multiport_mem_port
    import ahb_multiport_mem_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter int          MEM_BYTES    = 65536,
    parameter int          WAIT_MODE    = 0,
    parameter int          WAIT_CYCLES  = 0,
    parameter logic [31:0] LFSR_SEED    = 32'hACE1_2468,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
    parameter int          PORT         = 0,
    parameter int          IW           = $clog2(MEM_BYTES) - $clog2(XLEN / 8)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [1:0]        htrans_i,
    input  logic [XLEN-1:0]   haddr_i,
    input  logic              hwrite_i,
    input  logic [2:0]        hsize_i,
    input  logic [XLEN-1:0]   hwdata_i,
    output logic              hready_o,
    output logic              hresp_o,
    output logic              rd_en_o,
    output logic [IW-1:0]     ridx_o,
    output logic              wen_o,
    output logic [IW-1:0]     widx_o,
    output logic [XLEN/8-1:0] wstrb_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic              dphase_o,
    output logic              dwrite_o,
    output logic [XLEN-1:0]   daddr_o
);

    localparam int          LG   = $clog2(XLEN / 8);
    localparam int          AW   = $clog2(MEM_BYTES);
    localparam logic [15:0] SEED = 16'(LFSR_SEED ^ 32'(PORT));

    port_state_e     state_q;
    logic            hready_q, hresp_q;
    logic [XLEN-1:0] addr_q;
    logic [2:0]      size_q;
    logic            write_q, mem_q;
    logic [3:0]      cnt_q;
    logic [15:0]     lfsr_q;

    logic            accept, in_mem, is_mmio, bad;
    logic [XLEN-1:0] align_mask;
    logic [3:0]      wait_load;
    logic [7:0]      strb_full;
    logic            unused_strb;

    assign accept     = hready_q && (htrans_i == HTRANS_NONSEQ || htrans_i == HTRANS_SEQ);
    assign in_mem     = haddr_i < XLEN'(MEM_BYTES);
    assign is_mmio    = (haddr_i == XLEN'(CONSOLE_ADDR)) || (haddr_i == XLEN'(PASS_ADDR));
    assign align_mask = (XLEN'(1) << hsize_i) - XLEN'(1);
    assign bad        = (!in_mem && !is_mmio) || (hsize_i > 3'(LG)) ||
                        ((haddr_i & align_mask) != '0) || (is_mmio && !hwrite_i);
    assign wait_load  = (WAIT_MODE == 1) ? 4'({1'b0, lfsr_q[3:0]} % 5'(WAIT_CYCLES + 1))
                                         : 4'(WAIT_CYCLES);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
            cnt_q    <= '0;
            lfsr_q   <= SEED;
            addr_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            mem_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q  <= ST_DATA;
                        hready_q <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state_q  <= ST_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_ERROR;
                end
                default: begin
                    // IDLE, DATA and ERR2 all present hready=1 and may take a new address phase
                    if (accept) begin
                        addr_q  <= haddr_i;
                        size_q  <= hsize_i;
                        write_q <= hwrite_i;
                        mem_q   <= in_mem;
                        lfsr_q  <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
                        if (bad) begin
                            state_q  <= ST_ERR1;
                            hready_q <= 1'b0;
                            hresp_q  <= HRESP_ERROR;
                        end else if (wait_load != 4'd0) begin
                            state_q  <= ST_WAIT;
                            hready_q <= 1'b0;
                            hresp_q  <= HRESP_OKAY;
                            cnt_q    <= wait_load;
                        end else begin
                            state_q  <= ST_DATA;
                            hready_q <= 1'b1;
                            hresp_q  <= HRESP_OKAY;
                        end
                    end else begin
                        state_q  <= ST_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    assign hready_o    = hready_q;
    assign hresp_o     = hresp_q;
    assign dphase_o    = (state_q == ST_DATA);
    assign dwrite_o    = write_q;
    assign daddr_o     = addr_q;
    assign rd_en_o     = dphase_o && !write_q;
    assign ridx_o      = addr_q[AW-1:LG];
    assign widx_o      = addr_q[AW-1:LG];
    assign wen_o       = dphase_o && write_q && mem_q;
    assign strb_full   = strb(size_q, 3'(addr_q[LG-1:0]));
    assign wstrb_o     = strb_full[XLEN/8-1:0];
    assign wdata_o     = hwdata_i;
    assign unused_strb = ^strb_full;

endmodule

// File: rtl/ahb_multiport_mem.sv
// rtl/ahb_multiport_mem.sv - NPORTS AHB-Lite slave ports over one shared memory with console/pass MMIO
module ahb_multiport_mem
    import ahb_multiport_mem_pkg::*;
#(
    parameter int          NPORTS       = 2,
    parameter int          XLEN         = 32,
    parameter int          MEM_BYTES    = 65536,
    parameter int          WAIT_MODE    = 0,
    parameter int          WAIT_CYCLES  = 0,
    parameter logic [31:0] LFSR_SEED    = 32'hACE1_2468,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
    parameter logic [31:0] PASS_VALUE   = 32'd123456789
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2*NPORTS-1:0]    htrans,
    input  logic [XLEN*NPORTS-1:0] haddr,
    input  logic [NPORTS-1:0]      hwrite,
    input  logic [3*NPORTS-1:0]    hsize,
    input  logic [3*NPORTS-1:0]    hburst,
    input  logic [XLEN*NPORTS-1:0] hwdata,
    output logic [XLEN*NPORTS-1:0] hrdata,
    output logic [NPORTS-1:0]      hready,
    output logic [NPORTS-1:0]      hresp,
    output logic                   console_valid,
    output logic [7:0]             console_data,
    output logic                   tests_passed
);

    localparam int IW    = $clog2(MEM_BYTES) - $clog2(XLEN / 8);
    localparam int WORDS = 1 << IW;

    logic [XLEN-1:0]   mem_q [WORDS];
    logic              tests_passed_q;
    logic              pass_hit;
    logic              unused_hburst;

    logic [NPORTS-1:0] p_wen, p_rd_en, p_dphase, p_dwrite;
    logic [IW-1:0]     p_widx  [NPORTS];
    logic [IW-1:0]     p_ridx  [NPORTS];
    logic [XLEN/8-1:0] p_wstrb [NPORTS];
    logic [XLEN-1:0]   p_wdata [NPORTS];
    logic [XLEN-1:0]   p_daddr [NPORTS];

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        ahb_multiport_mem_port #(
            .XLEN(XLEN), .MEM_BYTES(MEM_BYTES), .WAIT_MODE(WAIT_MODE), .WAIT_CYCLES(WAIT_CYCLES),
            .LFSR_SEED(LFSR_SEED), .CONSOLE_ADDR(CONSOLE_ADDR), .PASS_ADDR(PASS_ADDR), .PORT(p)
        ) u_port (
            .clk_i    (clk),
            .reset_i  (reset),
            .htrans_i (htrans[2*p +: 2]),
            .haddr_i  (haddr[XLEN*p +: XLEN]),
            .hwrite_i (hwrite[p]),
            .hsize_i  (hsize[3*p +: 3]),
            .hwdata_i (hwdata[XLEN*p +: XLEN]),
            .hready_o (hready[p]),
            .hresp_o  (hresp[p]),
            .rd_en_o  (p_rd_en[p]),
            .ridx_o   (p_ridx[p]),
            .wen_o    (p_wen[p]),
            .widx_o   (p_widx[p]),
            .wstrb_o  (p_wstrb[p]),
            .wdata_o  (p_wdata[p]),
            .dphase_o (p_dphase[p]),
            .dwrite_o (p_dwrite[p]),
            .daddr_o  (p_daddr[p])
        );
        // Asynchronous read: a same-cycle write lands at the edge, so readers see the old word
        assign hrdata[XLEN*p +: XLEN] = p_rd_en[p] ? mem_q[p_ridx[p]] : '0;
    end

    // Later loop iterations override earlier ones, so the highest port wins each byte
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int p = 0; p < NPORTS; p++) begin
                for (int b = 0; b < XLEN / 8; b++) begin
                    if (p_wen[p] && p_wstrb[p][b]) begin
                        mem_q[p_widx[p]][8*b +: 8] <= p_wdata[p][8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        console_valid = 1'b0;
        console_data  = 8'h00;
        pass_hit      = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            if (p_dphase[p] && p_dwrite[p]) begin
                if (p_daddr[p] == XLEN'(CONSOLE_ADDR)) begin
                    console_valid = 1'b1;
                    console_data  = p_wdata[p][7:0];
                end
                if (p_daddr[p] == XLEN'(PASS_ADDR) && p_wdata[p][31:0] == PASS_VALUE) begin
                    pass_hit = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tests_passed_q <= 1'b0;
        end else if (pass_hit) begin
            tests_passed_q <= 1'b1;
        end
    end

    assign tests_passed  = tests_passed_q;
    assign unused_hburst = ^hburst;

endmodule

// File: tb/tb_ahb_multiport_mem.sv
// tb/tb_ahb_multiport_mem.sv - directed self-checking bench for ahb_multiport_mem (zero-wait and 3-wait instances)
module tb_ahb_multiport_mem;

    localparam logic [31:0] CON  = 32'h1000_0000;
    localparam logic [31:0] PASS = 32'h2000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, sel;
    logic [3:0]  htrans_b, htrans0, htrans3;
    logic [63:0] haddr_b, hwdata_b;
    logic [1:0]  hwrite_b;
    logic [5:0]  hsize_b, hburst_b;
    logic [63:0] hrdata0, hrdata3, hrdata_m;
    logic [1:0]  hready0, hready3, hready_m, hresp0, hresp3, hresp_m;
    logic        cv0, cv3, tp0, tp3;
    logic [7:0]  cd0, cd3;

    int n_checks = 0;
    int n_fail   = 0;

    // sel steers the bench's bus onto one instance; the other sees IDLE
    assign htrans0  = sel ? 4'b0000 : htrans_b;
    assign htrans3  = sel ? htrans_b : 4'b0000;
    assign hrdata_m = sel ? hrdata3 : hrdata0;
    assign hready_m = sel ? hready3 : hready0;
    assign hresp_m  = sel ? hresp3 : hresp0;

    ahb_multiport_mem #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .htrans(htrans0), .haddr(haddr_b), .hwrite(hwrite_b),
        .hsize(hsize_b), .hburst(hburst_b), .hwdata(hwdata_b), .hrdata(hrdata0),
        .hready(hready0), .hresp(hresp0), .console_valid(cv0), .console_data(cd0),
        .tests_passed(tp0)
    );

    ahb_multiport_mem #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .htrans(htrans3), .haddr(haddr_b), .hwrite(hwrite_b),
        .hsize(hsize_b), .hburst(hburst_b), .hwdata(hwdata_b), .hrdata(hrdata3),
        .hready(hready3), .hresp(hresp3), .console_valid(cv3), .console_data(cd3),
        .tests_passed(tp3)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic addr_phase(input int p, input logic wr, input logic [31:0] addr, input logic [2:0] size);
        htrans_b[2*p +: 2] = 2'b10;
        haddr_b[32*p +: 32] = addr;
        hwrite_b[p] = wr;
        hsize_b[3*p +: 3] = size;
    endtask

    // Called and returns at posedge+1; waits is bounded at 20 cycles
    task automatic xfer(input int p, input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wd, output int waits, output logic r_first,
                        output logic r_last, output logic [31:0] rd);
        addr_phase(p, wr, addr, size);
        @(posedge clk); #1;
        htrans_b[2*p +: 2] = 2'b00;
        hwdata_b[32*p +: 32] = wd;
        waits = 0;
        @(negedge clk);
        r_first = hresp_m[p];
        while (!hready_m[p] && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        r_last = hresp_m[p];
        rd = hrdata_m[32*p +: 32];
        @(posedge clk); #1;
    endtask

    initial begin
        int          w;
        logic        rf, rl;
        logic [31:0] rd;

        reset = 1'b1; sel = 1'b0; htrans_b = '0; haddr_b = '0; hwdata_b = '0;
        hwrite_b = '0; hsize_b = '0; hburst_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_hready0", 64'(hready0), 64'h3);
        check_eq("rst_hresp0", 64'(hresp0), 64'h0);
        check_eq("rst_hrdata0", hrdata0, 64'h0);
        check_eq("rst_console0", 64'(cv0), 64'h0);
        check_eq("rst_passed0", 64'(tp0), 64'h0);
        check_eq("rst_hready3", 64'(hready3), 64'h3);
        check_eq("rst_misc3", {54'h0, cd3, cv3, tp3}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // zero-wait write then read
        xfer(0, 1'b1, 32'h100, 3'd2, 32'hDEAD_BEEF, w, rf, rl, rd);
        check_eq("t1_wr_waits", 64'(w), 64'd0);
        xfer(0, 1'b0, 32'h100, 3'd2, 32'h0, w, rf, rl, rd);
        check_eq("t1_rd_waits", 64'(w), 64'd0);
        check_eq("t1_rd_data", 64'(rd), 64'hDEAD_BEEF);
        check_eq("t1_rd_resp", 64'(rl), 64'h0);

        // pipelined NONSEQ/SEQ reads
        xfer(0, 1'b1, 32'h104, 3'd2, 32'h5555_AAAA, w, rf, rl, rd);
        addr_phase(0, 1'b0, 32'h100, 3'd2);
        @(posedge clk); #1;
        addr_phase(0, 1'b0, 32'h104, 3'd2);
        htrans_b[1:0] = 2'b11;
        @(negedge clk);
        check_eq("pipe_beat0", hrdata0[31:0], 64'hDEAD_BEEF);
        @(posedge clk); #1;
        htrans_b[1:0] = 2'b00;
        @(negedge clk);
        check_eq("pipe_beat1", hrdata0[31:0], 64'h5555_AAAA);
        check_eq("pipe_ready", 64'(hready0[0]), 64'h1);
        @(posedge clk); #1;

        // byte lane write, misaligned halfword error
        xfer(0, 1'b1, 32'h200, 3'd2, 32'h1122_3344, w, rf, rl, rd);
        xfer(0, 1'b1, 32'h203, 3'd0, 32'hAA55_5555, w, rf, rl, rd);
        xfer(0, 1'b0, 32'h200, 3'd2, 32'h0, w, rf, rl, rd);
        check_eq("t3_byte_merge", 64'(rd), 64'hAA22_3344);
        xfer(0, 1'b1, 32'h201, 3'd1, 32'hFFFF_FFFF, w, rf, rl, rd);
        check_eq("t3_err_waits", 64'(w), 64'd1);
        check_eq("t3_err1_resp", 64'(rf), 64'h1);
        check_eq("t3_err2_resp", 64'(rl), 64'h1);
        @(negedge clk);
        check_eq("t3_err_idle", {62'h0, hready0[0], hresp0[0]}, 64'h2);
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h200, 3'd2, 32'h0, w, rf, rl, rd);
        check_eq("t3_unchanged", 64'(rd), 64'hAA22_3344);

        // out-of-range, oversize and MMIO reads
        xfer(0, 1'b0, 32'h0001_0000, 3'd2, 32'h0, w, rf, rl, rd);
        check_eq("t4_oob_err", {62'h0, rf, rl}, 64'h3);
        check_eq("t4_oob_waits", 64'(w), 64'd1);
        @(negedge clk);
        check_eq("t4_oob_idle", {62'h0, hready0[0], hresp0[0]}, 64'h2);
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h0, 3'd3, 32'h0, w, rf, rl, rd);
        check_eq("t4_hsize3_err", {62'h0, rf, rl}, 64'h3);
        xfer(0, 1'b0, CON, 3'd2, 32'h0, w, rf, rl, rd);
        check_eq("t4_mmio_rd_err", {62'h0, rf, rl}, 64'h3);

        // same-cycle collisions
        addr_phase(0, 1'b1, 32'h300, 3'd2);
        addr_phase(1, 1'b1, 32'h300, 3'd2);
        @(posedge clk); #1;
        htrans_b = 4'b0000;
        hwdata_b = {32'h2, 32'h1};
        @(negedge clk);
        check_eq("t5_both_ready", 64'(hready0), 64'h3);
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h300, 3'd2, 32'h0, w, rf, rl, rd);
        check_eq("t5_high_wins", 64'(rd), 64'h2);
        addr_phase(0, 1'b1, 32'h300, 3'd2);
        addr_phase(1, 1'b0, 32'h300, 3'd2);
        @(posedge clk); #1;
        htrans_b = 4'b0000;
        hwdata_b[31:0] = 32'h3;
        @(negedge clk);
        check_eq("t5_read_old", hrdata0[63:32], 64'h2);
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h300, 3'd2, 32'h0, w, rf, rl, rd);
        check_eq("t5_new_val", 64'(rd), 64'h3);

        // console and pass MMIO
        addr_phase(0, 1'b1, CON, 3'd0);
        @(posedge clk); #1;
        htrans_b[1:0] = 2'b00;
        hwdata_b[31:0] = 32'h0000_0041;
        @(negedge clk);
        check_eq("t6_con_valid", 64'(cv0), 64'h1);
        check_eq("t6_con_data", 64'(cd0), 64'h41);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("t6_con_pulse", 64'(cv0), 64'h0);
        @(posedge clk); #1;
        xfer(0, 1'b1, PASS, 3'd2, 32'd5, w, rf, rl, rd);
        @(negedge clk);
        check_eq("t6_pass_wrong", 64'(tp0), 64'h0);
        @(posedge clk); #1;
        xfer(0, 1'b1, PASS, 3'd2, 32'd123456789, w, rf, rl, rd);
        @(negedge clk);
        check_eq("t6_pass_set", 64'(tp0), 64'h1);
        @(posedge clk); #1;
        xfer(0, 1'b1, PASS, 3'd2, 32'd0, w, rf, rl, rd);
        @(negedge clk);
        check_eq("t6_pass_sticky", 64'(tp0), 64'h1);
        @(posedge clk); #1;

        // reset during a write data phase drops the write and clears tests_passed
        addr_phase(0, 1'b1, 32'h100, 3'd2);
        @(posedge clk); #1;
        htrans_b[1:0] = 2'b00;
        hwdata_b[31:0] = 32'h0BAD_F00D;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("t7_rst_passed", 64'(tp0), 64'h0);
        check_eq("t7_rst_ready", 64'(hready0), 64'h3);
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h100, 3'd2, 32'h0, w, rf, rl, rd);
        check_eq("t7_write_dropped", 64'(rd), 64'hDEAD_BEEF);

        // three wait states on the second instance
        sel = 1'b1;
        xfer(1, 1'b1, 32'h200, 3'd2, 32'h1122_3344, w, rf, rl, rd);
        check_eq("t2_wr_waits", 64'(w), 64'd3);
        xfer(1, 1'b0, 32'h200, 3'd2, 32'h0, w, rf, rl, rd);
        check_eq("t2_rd_waits", 64'(w), 64'd3);
        check_eq("t2_rd_data", 64'(rd), 64'h1122_3344);
        addr_phase(1, 1'b0, 32'h200, 3'd2);
        @(posedge clk); #1;
        htrans_b[3:2] = 2'b00;
        @(negedge clk);
        check_eq("t2_in_wait", 64'(hready3[1]), 64'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("t2_rst_ready", 64'(hready3), 64'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
